// File: rtl/bram2be_queued.sv
// True dual-port byte-enable RAM with a valid/ready handshake and a credit-limited response FIFO per port.
module bram2be_queued #(
   parameter int ADDR_WIDTH = 10,
   parameter int CHUNKSIZE  = 8,
   parameter int WE_WIDTH   = 4,
   parameter int MEMSIZE    = 1024,
   parameter int PIPELINED  = 0,
   parameter int RESP_DEPTH = 2,
   parameter     INIT_FILE  = "mem.vmh",
   localparam int DATA_WIDTH = WE_WIDTH * CHUNKSIZE
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic [WE_WIDTH-1:0]   a_req_we,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_resp_valid,
   input  logic                  a_resp_ready,
   output logic [DATA_WIDTH-1:0] a_resp_data,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic [WE_WIDTH-1:0]   b_req_we,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   output logic                  b_resp_valid,
   input  logic                  b_resp_ready,
   output logic [DATA_WIDTH-1:0] b_resp_data
);

   localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] ram [MEMSIZE];

   // Index 0 is port A, index 1 is port B.
   logic                  req_valid  [2];
   logic [WE_WIDTH-1:0]   req_we     [2];
   logic [ADDR_WIDTH-1:0] req_addr   [2];
   logic [DATA_WIDTH-1:0] req_wdata  [2];
   logic                  req_ready  [2];
   logic                  resp_valid [2];
   logic                  resp_ready [2];
   logic [DATA_WIDTH-1:0] resp_data  [2];
   logic                  accept     [2];
   logic                  wr_en      [2];
   logic [IDX_W-1:0]      idx        [2];
   logic                  rst_done;

   assign req_valid[0]  = a_req_valid;
   assign req_we[0]     = a_req_we;
   assign req_addr[0]   = a_req_addr;
   assign req_wdata[0]  = a_req_wdata;
   assign resp_ready[0] = a_resp_ready;
   assign req_valid[1]  = b_req_valid;
   assign req_we[1]     = b_req_we;
   assign req_addr[1]   = b_req_addr;
   assign req_wdata[1]  = b_req_wdata;
   assign resp_ready[1] = b_resp_ready;

   assign a_req_ready  = req_ready[0];
   assign a_resp_valid = resp_valid[0];
   assign a_resp_data  = resp_data[0];
   assign b_req_ready  = req_ready[1];
   assign b_resp_valid = resp_valid[1];
   assign b_resp_data  = resp_data[1];

   // INIT_FILE is accepted as a parameter but no file is read; memory starts undefined.
   if ($bits(INIT_FILE) == 0) begin : g_no_init_file
   end

   // Requests are refused until the first edge after reset releases.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rst_done <= 1'b0;
      else        rst_done <= 1'b1;
   end

   // Port A's lane update is scheduled last so it wins lanes both ports enable.
   always_ff @(posedge CLK) begin
      for (int l = 0; l < WE_WIDTH; l++) begin
         if (wr_en[1] && req_we[1][l])
            ram[idx[1]][l*CHUNKSIZE +: CHUNKSIZE] <= req_wdata[1][l*CHUNKSIZE +: CHUNKSIZE];
         if (wr_en[0] && req_we[0][l])
            ram[idx[0]][l*CHUNKSIZE +: CHUNKSIZE] <= req_wdata[0][l*CHUNKSIZE +: CHUNKSIZE];
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic                  in_range;
      logic                  s1_valid;
      logic                  s1_in_range;
      logic [WE_WIDTH-1:0]   s1_we;
      logic [DATA_WIDTH-1:0] s1_old;
      logic [DATA_WIDTH-1:0] s1_wdata;
      logic [DATA_WIDTH-1:0] s1_merged;
      logic                  push;
      logic [DATA_WIDTH-1:0] push_data;
      logic                  pop;
      logic [DATA_WIDTH-1:0] fifo [RESP_DEPTH];
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      rd_ptr;
      logic [CNT_W-1:0]      used;
      logic [CNT_W-1:0]      credits;

      assign in_range     = 32'(req_addr[p]) < 32'(MEMSIZE);
      assign idx[p]       = req_addr[p][IDX_W-1:0];
      assign req_ready[p] = rst_done && (credits < CNT_W'(RESP_DEPTH));
      assign accept[p]    = req_valid[p] && req_ready[p];
      assign wr_en[p]     = accept[p] && in_range;

      // The old word is captured in the same edge as the write, giving read-before-write across ports.
      always_ff @(posedge CLK) begin
         if (accept[p]) begin
            s1_old      <= ram[idx[p]];
            s1_we       <= req_we[p];
            s1_wdata    <= req_wdata[p];
            s1_in_range <= in_range;
         end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) s1_valid <= 1'b0;
         else        s1_valid <= accept[p];
      end

      always_comb begin
         s1_merged = '0;
         if (s1_in_range) begin
            for (int l = 0; l < WE_WIDTH; l++)
               s1_merged[l*CHUNKSIZE +: CHUNKSIZE] = s1_we[l] ? s1_wdata[l*CHUNKSIZE +: CHUNKSIZE]
                                                              : s1_old[l*CHUNKSIZE +: CHUNKSIZE];
         end
      end

      if (PIPELINED != 0) begin : g_pipe
         logic                  s2_valid;
         logic [DATA_WIDTH-1:0] s2_data;

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) s2_valid <= 1'b0;
            else        s2_valid <= s1_valid;
         end

         always_ff @(posedge CLK) begin
            if (s1_valid) s2_data <= s1_merged;
         end

         assign push      = s2_valid;
         assign push_data = s2_data;
      end else begin : g_nopipe
         assign push      = s1_valid;
         assign push_data = s1_merged;
      end

      assign resp_valid[p] = (used != '0);
      assign pop           = resp_valid[p] && resp_ready[p];
      assign resp_data[p]  = resp_valid[p] ? fifo[rd_ptr] : '0;

      always_ff @(posedge CLK) begin
         if (push) fifo[wr_ptr] <= push_data;
      end

      // Credits cover in-flight plus buffered responses, so a push always finds a free slot.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            used    <= '0;
            credits <= '0;
         end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   used <= used + 1'b1;
               2'b01:   used <= used - 1'b1;
               default: ;
            endcase
            case ({accept[p], pop})
               2'b10:   credits <= credits + 1'b1;
               2'b01:   credits <= credits - 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bram2be_queued.sv
// Directed bench for bram2be_queued: one latency-1 instance (depth 2) and one latency-2 instance (depth 4, 11-bit address).
module tb_bram2be_queued;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST_N;
   int   checks   = 0;
   int   failures = 0;

   logic        a0_req_valid, a0_req_ready, a0_resp_valid, a0_resp_ready;
   logic [3:0]  a0_req_we;
   logic [9:0]  a0_req_addr;
   logic [31:0] a0_req_wdata, a0_resp_data;
   logic        b0_req_valid, b0_req_ready, b0_resp_valid, b0_resp_ready;
   logic [3:0]  b0_req_we;
   logic [9:0]  b0_req_addr;
   logic [31:0] b0_req_wdata, b0_resp_data;

   logic        a1_req_valid, a1_req_ready, a1_resp_valid, a1_resp_ready;
   logic [3:0]  a1_req_we;
   logic [10:0] a1_req_addr;
   logic [31:0] a1_req_wdata, a1_resp_data;
   logic        b1_req_valid, b1_req_ready, b1_resp_valid, b1_resp_ready;
   logic [3:0]  b1_req_we;
   logic [10:0] b1_req_addr;
   logic [31:0] b1_req_wdata, b1_resp_data;

   bram2be_queued #(.PIPELINED(0), .RESP_DEPTH(2)) dut0 (
      .CLK(CLK), .RST_N(RST_N),
      .a_req_valid(a0_req_valid), .a_req_ready(a0_req_ready), .a_req_we(a0_req_we),
      .a_req_addr(a0_req_addr), .a_req_wdata(a0_req_wdata), .a_resp_valid(a0_resp_valid),
      .a_resp_ready(a0_resp_ready), .a_resp_data(a0_resp_data),
      .b_req_valid(b0_req_valid), .b_req_ready(b0_req_ready), .b_req_we(b0_req_we),
      .b_req_addr(b0_req_addr), .b_req_wdata(b0_req_wdata), .b_resp_valid(b0_resp_valid),
      .b_resp_ready(b0_resp_ready), .b_resp_data(b0_resp_data)
   );

   bram2be_queued #(.ADDR_WIDTH(11), .MEMSIZE(1024), .PIPELINED(1), .RESP_DEPTH(4)) dut1 (
      .CLK(CLK), .RST_N(RST_N),
      .a_req_valid(a1_req_valid), .a_req_ready(a1_req_ready), .a_req_we(a1_req_we),
      .a_req_addr(a1_req_addr), .a_req_wdata(a1_req_wdata), .a_resp_valid(a1_resp_valid),
      .a_resp_ready(a1_resp_ready), .a_resp_data(a1_resp_data),
      .b_req_valid(b1_req_valid), .b_req_ready(b1_req_ready), .b_req_we(b1_req_we),
      .b_req_addr(b1_req_addr), .b_req_wdata(b1_req_wdata), .b_resp_valid(b1_resp_valid),
      .b_resp_ready(b1_resp_ready), .b_resp_data(b1_resp_data)
   );

   // Single request on dut0 port A; returns resp_valid one cycle after acceptance and the response one cycle later.
   task automatic a0_txn(input logic [3:0] we, input logic [9:0] addr, input logic [31:0] wdata,
                         output logic mid_valid, output logic valid, output logic [31:0] data);
      @(negedge CLK);
      a0_req_valid = 1'b1; a0_req_we = we; a0_req_addr = addr; a0_req_wdata = wdata;
      @(negedge CLK);
      a0_req_valid = 1'b0; a0_req_we = 4'h0;
      mid_valid = a0_resp_valid;
      @(negedge CLK);
      valid = a0_resp_valid; data = a0_resp_data;
   endtask

   // Single request on dut1 port A (two-cycle latency).
   task automatic a1_txn(input logic [3:0] we, input logic [10:0] addr, input logic [31:0] wdata,
                         output logic mid_valid, output logic valid, output logic [31:0] data);
      @(negedge CLK);
      a1_req_valid = 1'b1; a1_req_we = we; a1_req_addr = addr; a1_req_wdata = wdata;
      @(negedge CLK);
      a1_req_valid = 1'b0; a1_req_we = 4'h0;
      @(negedge CLK);
      mid_valid = a1_resp_valid;
      @(negedge CLK);
      valid = a1_resp_valid; data = a1_resp_data;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      checks++; if (a0_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_a0_resp_valid got=%b exp=0", a0_resp_valid); end
      checks++; if (a0_resp_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_a0_resp_data got=%h exp=0", a0_resp_data); end
      checks++; if (b0_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_b0_resp_valid got=%b exp=0", b0_resp_valid); end
      checks++; if (a1_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_a1_resp_valid got=%b exp=0", a1_resp_valid); end
      checks++; if (a0_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_a0_ready_held got=%b exp=0", a0_req_ready); end
      RST_N = 1'b1;
      @(negedge CLK);
      checks++; if (a0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_a0_ready got=%b exp=1", a0_req_ready); end
      checks++; if (b0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_b0_ready got=%b exp=1", b0_req_ready); end
      checks++; if (a1_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_a1_ready got=%b exp=1", a1_req_ready); end
      checks++; if (b1_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_b1_ready got=%b exp=1", b1_req_ready); end
   endtask

   task automatic test_write_read();
      logic mv, v;
      logic [31:0] d;
      a0_txn(4'hF, 10'd5, 32'hDEADBEEF, mv, v, d);
      checks++; if (mv !== 1'b0) begin failures++; $display("[TB] FAIL wr_no_bypass got=%b exp=0", mv); end
      checks++; if (v !== 1'b1) begin failures++; $display("[TB] FAIL wr_resp_valid got=%b exp=1", v); end
      checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_resp_data got=%h exp=deadbeef", d); end
      a0_txn(4'h0, 10'd5, 32'h0, mv, v, d);
      checks++; if (v !== 1'b1 || d !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_addr5 got=%b/%h exp=1/deadbeef", v, d); end
   endtask

   task automatic test_byte_enables();
      logic mv, v;
      logic [31:0] d;
      a0_txn(4'hF, 10'd7, 32'h11223344, mv, v, d);
      checks++; if (d !== 32'h11223344) begin failures++; $display("[TB] FAIL be_init got=%h exp=11223344", d); end
      a0_txn(4'b0101, 10'd7, 32'hAABBCCDD, mv, v, d);
      checks++; if (v !== 1'b1 || d !== 32'h11BB33DD) begin failures++; $display("[TB] FAIL be_merge_resp got=%b/%h exp=1/11bb33dd", v, d); end
      a0_txn(4'h0, 10'd7, 32'h0, mv, v, d);
      checks++; if (d !== 32'h11BB33DD) begin failures++; $display("[TB] FAIL be_readback got=%h exp=11bb33dd", d); end
   endtask

   task automatic test_backpressure();
      logic mv, v;
      logic [31:0] d;
      a0_txn(4'hF, 10'd20, 32'hA0A00020, mv, v, d);
      a0_txn(4'hF, 10'd21, 32'hA1A10021, mv, v, d);
      a0_txn(4'hF, 10'd22, 32'hA2A20022, mv, v, d);
      @(negedge CLK);
      a0_resp_ready = 1'b0;
      a0_req_valid = 1'b1; a0_req_we = 4'h0; a0_req_addr = 10'd20;
      checks++; if (a0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready0 got=%b exp=1", a0_req_ready); end
      @(negedge CLK);
      checks++; if (a0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready1 got=%b exp=1", a0_req_ready); end
      checks++; if (a0_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_valid1 got=%b exp=0", a0_resp_valid); end
      a0_req_addr = 10'd21;
      @(negedge CLK);
      checks++; if (a0_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready2 got=%b exp=0", a0_req_ready); end
      checks++; if (a0_resp_valid !== 1'b1 || a0_resp_data !== 32'hA0A00020) begin failures++; $display("[TB] FAIL bp_head2 got=%b/%h exp=1/a0a00020", a0_resp_valid, a0_resp_data); end
      a0_req_addr = 10'd22;
      @(negedge CLK);
      checks++; if (a0_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready3 got=%b exp=0", a0_req_ready); end
      checks++; if (a0_resp_data !== 32'hA0A00020) begin failures++; $display("[TB] FAIL bp_hold3 got=%h exp=a0a00020", a0_resp_data); end
      a0_resp_ready = 1'b1;
      @(negedge CLK);
      checks++; if (a0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready4 got=%b exp=1", a0_req_ready); end
      checks++; if (a0_resp_valid !== 1'b1 || a0_resp_data !== 32'hA1A10021) begin failures++; $display("[TB] FAIL bp_head4 got=%b/%h exp=1/a1a10021", a0_resp_valid, a0_resp_data); end
      @(negedge CLK);
      a0_req_valid = 1'b0;
      checks++; if (a0_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_gap5 got=%b exp=0", a0_resp_valid); end
      @(negedge CLK);
      checks++; if (a0_resp_valid !== 1'b1 || a0_resp_data !== 32'hA2A20022) begin failures++; $display("[TB] FAIL bp_third got=%b/%h exp=1/a2a20022", a0_resp_valid, a0_resp_data); end
      @(negedge CLK);
      checks++; if (a0_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained got=%b exp=0", a0_resp_valid); end
   endtask

   task automatic test_collision();
      logic mv, v;
      logic [31:0] d;
      a0_txn(4'hF, 10'd9, 32'h0, mv, v, d);
      a0_txn(4'hF, 10'd10, 32'h0, mv, v, d);
      @(negedge CLK);
      a0_req_valid = 1'b1; a0_req_we = 4'b0001; a0_req_addr = 10'd9; a0_req_wdata = 32'h000000FF;
      b0_req_valid = 1'b1; b0_req_we = 4'b0011; b0_req_addr = 10'd9; b0_req_wdata = 32'hFFFFFFFF;
      @(negedge CLK);
      a0_req_valid = 1'b0; b0_req_valid = 1'b0;
      @(negedge CLK);
      checks++; if (a0_resp_valid !== 1'b1 || a0_resp_data !== 32'h000000FF) begin failures++; $display("[TB] FAIL ww_a_resp got=%b/%h exp=1/000000ff", a0_resp_valid, a0_resp_data); end
      checks++; if (b0_resp_valid !== 1'b1 || b0_resp_data !== 32'h0000FFFF) begin failures++; $display("[TB] FAIL ww_b_resp got=%b/%h exp=1/0000ffff", b0_resp_valid, b0_resp_data); end
      a0_txn(4'h0, 10'd9, 32'h0, mv, v, d);
      checks++; if (d !== 32'h0000FFFF) begin failures++; $display("[TB] FAIL ww_mem got=%h exp=0000ffff", d); end
      @(negedge CLK);
      a0_req_valid = 1'b1; a0_req_we = 4'hF; a0_req_addr = 10'd10; a0_req_wdata = 32'h12345678;
      b0_req_valid = 1'b1; b0_req_we = 4'h0; b0_req_addr = 10'd10;
      @(negedge CLK);
      a0_req_valid = 1'b0; b0_req_valid = 1'b0;
      @(negedge CLK);
      checks++; if (a0_resp_data !== 32'h12345678) begin failures++; $display("[TB] FAIL wr_a_resp got=%h exp=12345678", a0_resp_data); end
      checks++; if (b0_resp_valid !== 1'b1 || b0_resp_data !== 32'h0) begin failures++; $display("[TB] FAIL wr_b_old got=%b/%h exp=1/00000000", b0_resp_valid, b0_resp_data); end
      @(negedge CLK);
      a0_req_valid = 1'b1; a0_req_we = 4'h0; a0_req_addr = 10'd9;
      b0_req_valid = 1'b1; b0_req_we = 4'hF; b0_req_addr = 10'd9; b0_req_wdata = 32'h55555555;
      @(negedge CLK);
      a0_req_valid = 1'b0; b0_req_valid = 1'b0; b0_req_we = 4'h0;
      @(negedge CLK);
      checks++; if (a0_resp_data !== 32'h0000FFFF) begin failures++; $display("[TB] FAIL rw_a_old got=%h exp=0000ffff", a0_resp_data); end
      checks++; if (b0_resp_data !== 32'h55555555) begin failures++; $display("[TB] FAIL rw_b_resp got=%h exp=55555555", b0_resp_data); end
      @(negedge CLK);
      a0_req_valid = 1'b1; a0_req_addr = 10'd10;
      b0_req_valid = 1'b1; b0_req_addr = 10'd10;
      @(negedge CLK);
      a0_req_valid = 1'b0; b0_req_valid = 1'b0;
      @(negedge CLK);
      checks++; if (a0_resp_data !== 32'h12345678) begin failures++; $display("[TB] FAIL rr_a got=%h exp=12345678", a0_resp_data); end
      checks++; if (b0_resp_data !== 32'h12345678) begin failures++; $display("[TB] FAIL rr_b got=%h exp=12345678", b0_resp_data); end
      a0_txn(4'h0, 10'd9, 32'h0, mv, v, d);
      checks++; if (d !== 32'h55555555) begin failures++; $display("[TB] FAIL rw_mem got=%h exp=55555555", d); end
   endtask

   task automatic test_streaming();
      logic mv, v;
      logic [31:0] d, exp_d;
      for (int i = 0; i < 8; i++) a1_txn(4'hF, 11'(i), 32'hC0DE0000 + 32'(i), mv, v, d);
      checks++; if (mv !== 1'b0 || v !== 1'b1) begin failures++; $display("[TB] FAIL pipe_latency got=%b%b exp=01", mv, v); end
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (k < 8) begin
            checks++; if (a1_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready k=%0d got=%b exp=1", k, a1_req_ready); end
         end
         if (k >= 3 && k <= 10) begin
            exp_d = 32'hC0DE0000 + 32'(k - 3);
            checks++; if (a1_resp_valid !== 1'b1 || a1_resp_data !== exp_d) begin failures++; $display("[TB] FAIL stream_resp k=%0d got=%b/%h exp=1/%h", k, a1_resp_valid, a1_resp_data, exp_d); end
         end else begin
            checks++; if (a1_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_idle k=%0d got=%b exp=0", k, a1_resp_valid); end
         end
         if (k < 8) begin
            a1_req_valid = 1'b1; a1_req_we = 4'h0; a1_req_addr = 11'(k);
         end else begin
            a1_req_valid = 1'b0;
         end
      end
      a1_txn(4'h0, 11'd1024, 32'h0, mv, v, d);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("[TB] FAIL oor_read got=%b/%h exp=1/00000000", v, d); end
      a1_txn(4'hF, 11'd1024, 32'hBADBAD00, mv, v, d);
      checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("[TB] FAIL oor_write got=%b/%h exp=1/00000000", v, d); end
      a1_txn(4'h0, 11'd0, 32'h0, mv, v, d);
      checks++; if (d !== 32'hC0DE0000) begin failures++; $display("[TB] FAIL oor_no_alias got=%h exp=c0de0000", d); end
   endtask

   task automatic test_reset_midstream();
      int acc;
      logic [31:0] exp_d;
      a1_resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         a1_req_valid = 1'b1; a1_req_we = 4'h0; a1_req_addr = 11'(k);
      end
      @(negedge CLK);
      a1_req_valid = 1'b0;
      checks++; if (a1_resp_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_valid got=%b exp=1", a1_resp_valid); end
      RST_N = 1'b0;
      #1;
      checks++; if (a1_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_valid got=%b exp=0", a1_resp_valid); end
      checks++; if (a1_resp_data !== 32'h0) begin failures++; $display("[TB] FAIL mid_async_data got=%h exp=0", a1_resp_data); end
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      checks++; if (a1_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready got=%b exp=1", a1_req_ready); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (a1_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_stale k=%0d got=%b exp=0", k, a1_resp_valid); end
         @(negedge CLK);
      end
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (a1_req_ready) begin
            a1_req_valid = 1'b1; a1_req_addr = 11'(4 + acc); acc++;
         end else begin
            a1_req_valid = 1'b0;
         end
      end
      @(negedge CLK);
      a1_req_valid = 1'b0;
      checks++; if (acc !== 4) begin failures++; $display("[TB] FAIL mid_credits got=%0d exp=4", acc); end
      checks++; if (a1_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_full got=%b exp=0", a1_req_ready); end
      a1_resp_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         exp_d = 32'hC0DE0004 + 32'(j);
         checks++; if (a1_resp_valid !== 1'b1 || a1_resp_data !== exp_d) begin failures++; $display("[TB] FAIL mid_order j=%0d got=%b/%h exp=1/%h", j, a1_resp_valid, a1_resp_data, exp_d); end
         @(negedge CLK);
      end
      checks++; if (a1_resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_empty got=%b exp=0", a1_resp_valid); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RST_N = 1'b0;
      a0_req_valid = 1'b0; a0_req_we = 4'h0; a0_req_addr = '0; a0_req_wdata = '0; a0_resp_ready = 1'b1;
      b0_req_valid = 1'b0; b0_req_we = 4'h0; b0_req_addr = '0; b0_req_wdata = '0; b0_resp_ready = 1'b1;
      a1_req_valid = 1'b0; a1_req_we = 4'h0; a1_req_addr = '0; a1_req_wdata = '0; a1_resp_ready = 1'b1;
      b1_req_valid = 1'b0; b1_req_we = 4'h0; b1_req_addr = '0; b1_req_wdata = '0; b1_resp_ready = 1'b1;
      test_reset();
      test_write_read();
      test_byte_enables();
      test_backpressure();
      test_collision();
      test_streaming();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
